// File: rtl/seq_mult_unit.sv
// seq_mult_unit: iterative shift-add multiplier, one multiplier bit per clock.
// Unsigned ops use plain add-and-shift; signed ops use radix-2 Booth recoding.
// With EARLY_EXIT=1, an unsigned op stops once the unconsumed multiplier bits
// are all zero and finishes the product alignment with a single wide shift.
//
// Ports:
//   clk, Reset_n          clock, async active-low reset
//   in_valid/in_ready     operand handshake (accepted only in IDLE)
//   in_signed, in_a, in_b operand mode, multiplicand, multiplier
//   out_valid/out_ready   product handshake (held in DONE until out_ready)
//   out_product           full 2*WIDTH product, holds last value in IDLE
//   busy                  high in CALC or DONE
//   iter_count            iterations completed for the current op
module seq_mult_unit #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0,
  parameter int CW         = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy,
  output logic [CW-1:0]      iter_count
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH:0]   hi, hi_nx;       // one guard bit so Booth sums never overflow
  logic [WIDTH-1:0] lo, lo_nx;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mrem, mrem_nx;   // original in_b >> k: bits not yet consumed
  logic             q_m1, q_nx;
  logic             sgn;
  logic [CW-1:0]    cnt_nx;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   addend;
  logic [CW-1:0]    sh;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      mcand       <= '0;
      mrem        <= '0;
      q_m1        <= 1'b0;
      sgn         <= 1'b0;
      iter_count  <= '0;
      out_product <= '0;
    end else begin
      state      <= state_nx;
      hi         <= hi_nx;
      lo         <= lo_nx;
      mrem       <= mrem_nx;
      q_m1       <= q_nx;
      iter_count <= cnt_nx;
      if (state == IDLE && in_valid) begin
        mcand <= in_a;
        sgn   <= in_signed;
      end
      // Product register is loaded once, so it stays stable through DONE and IDLE.
      if (state == CALC && state_nx == DONE)
        out_product <= {hi_nx[WIDTH-1:0], lo_nx};
    end
  end

  always_comb begin
    state_nx = state;
    hi_nx    = hi;
    lo_nx    = lo;
    mrem_nx  = mrem;
    q_nx     = q_m1;
    cnt_nx   = iter_count;
    acc      = hi;
    addend   = sgn ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
    sh       = FULL - iter_count;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx = CALC;
          hi_nx    = '0;
          lo_nx    = in_b;
          mrem_nx  = in_b;
          q_nx     = 1'b0;
          cnt_nx   = '0;
        end
      end
      CALC: begin
        if (EARLY_EXIT && !sgn && mrem == '0) begin
          // Remaining iterations would add nothing; do all their shifts at once.
          {hi_nx, lo_nx} = {hi, lo} >> sh;
          state_nx       = DONE;
        end else begin
          if (sgn) begin
            case ({lo[0], q_m1})
              2'b10:   acc = hi - addend;
              2'b01:   acc = hi + addend;
              default: acc = hi;
            endcase
          end else if (lo[0]) begin
            acc = hi + addend;
          end
          // Arithmetic shift for signed, logical for unsigned.
          hi_nx   = {sgn & acc[WIDTH], acc[WIDTH:1]};
          lo_nx   = {acc[0], lo[WIDTH-1:1]};
          q_nx    = lo[0];
          mrem_nx = mrem >> 1;
          cnt_nx  = iter_count + CW'(1);
          if (iter_count == LAST) state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Bench for seq_mult_unit: two WIDTH=8 instances (EARLY_EXIT 0 and 1) share
// one stimulus stream; a WIDTH=32 instance takes randomized ops with
// random output backpressure against an arithmetic reference.
module tb_seq_mult_unit;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 clk = ~clk;

  // shared 8-bit stimulus
  logic        v8 = 1'b0, s8 = 1'b0, or8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, ov8, busy8, rdy8e, ov8e, busy8e;
  logic [15:0] p8, p8e;
  logic [3:0]  ic8, ic8e;

  logic        v32 = 1'b0, s32 = 1'b0, or32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        rdy32, ov32, busy32;
  logic [63:0] p32;
  logic [5:0]  ic32;

  seq_mult_unit #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut8 (
    .clk(clk), .Reset_n(Reset_n), .in_valid(v8), .in_ready(rdy8), .in_signed(s8),
    .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(or8), .out_product(p8),
    .busy(busy8), .iter_count(ic8));

  seq_mult_unit #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut8e (
    .clk(clk), .Reset_n(Reset_n), .in_valid(v8), .in_ready(rdy8e), .in_signed(s8),
    .in_a(a8), .in_b(b8), .out_valid(ov8e), .out_ready(or8), .out_product(p8e),
    .busy(busy8e), .iter_count(ic8e));

  seq_mult_unit dut32 (
    .clk(clk), .Reset_n(Reset_n), .in_valid(v32), .in_ready(rdy32), .in_signed(s32),
    .in_a(a32), .in_b(b32), .out_valid(ov32), .out_ready(or32), .out_product(p32),
    .busy(busy32), .iter_count(ic32));

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [7:0]  a, b;
    logic        s;
    logic [15:0] p;
    int          c, ce, ie;   // cycles (EE=0), cycles (EE=1), iter_count (EE=1)
  } vec_t;

  // reference: exact product from plain arithmetic
  function automatic logic [15:0] ref8(input logic [7:0] a, b, input logic s);
    int pr;
    if (s) pr = int'($signed(a)) * int'($signed(b));
    else   pr = int'(a) * int'(b);
    return 16'(pr);
  endfunction

  function automatic logic [63:0] ref32(input logic [31:0] a, b, input logic s);
    if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return 64'(a) * 64'(b);
  endfunction

  function automatic int msb8(input logic [7:0] b);
    int m = -1;
    for (int i = 0; i < 8; i++) if (b[i]) m = i;
    return m;
  endfunction

  // One op through both 8-bit units; checks latency, product, iter_count,
  // optional stall in DONE, then the return to IDLE.
  task automatic op8(input logic [7:0] a, b, input logic s, input logic [15:0] ep,
                     input int ec, ece, eie, hold, input string nm);
    int cyc, cd, ce;
    logic [15:0] pd, pe;
    @(negedge clk); a8 = a; b8 = b; s8 = s; v8 = 1'b1; or8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, ":calc"}, {60'd0, busy8, busy8e, rdy8, rdy8e}, 64'b1100);
    cyc = 0; cd = 0; ce = 0;
    while (!(ov8 && ov8e) && cyc < 40) begin
      // noise on inputs during CALC must not matter
      v8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
      @(posedge clk); cyc++;
      @(negedge clk);
      if (ov8 && cd == 0) cd = cyc;
      if (ov8e && ce == 0) ce = cyc;
    end
    chk({nm, ":lat"}, 64'(cd), 64'(ec));
    chk({nm, ":lat_ee"}, 64'(ce), 64'(ece));
    chk({nm, ":prod"}, 64'(p8), 64'(ep));
    chk({nm, ":prod_ee"}, 64'(p8e), 64'(ep));
    chk({nm, ":iter"}, 64'(ic8), 64'd8);
    chk({nm, ":iter_ee"}, 64'(ic8e), 64'(eie));
    pd = p8; pe = p8e;
    for (int i = 0; i < hold; i++) begin
      v8 = 1'($urandom);
      @(posedge clk); @(negedge clk);
      chk({nm, ":hold"}, {14'd0, ov8, ov8e, rdy8, rdy8e, p8, pe ^ p8e, 16'd0},
          {14'd0, 4'b1100, pd, 16'd0, 16'd0});
    end
    v8 = 1'b0; or8 = 1'b1;
    @(posedge clk); @(negedge clk);
    or8 = 1'b0;
    chk({nm, ":idle"}, {42'd0, ov8, ov8e, rdy8, rdy8e, busy8, busy8e, p8},
        {42'd0, 6'b001100, ep});
  endtask

  vec_t tbl [12];
  int   seen;
  logic [7:0]  ra, rb;
  logic        rs;
  logic [63:0] e32;
  int   m, rce, rie, got;

  initial begin
    tbl[0]  = '{8'd255, 8'd255, 1'b0, 16'hFE01, 8, 8, 8};
    tbl[1]  = '{8'h80,  8'h80,  1'b1, 16'h4000, 8, 8, 8};
    tbl[2]  = '{8'hFD,  8'h05,  1'b1, 16'hFFF1, 8, 8, 8};
    tbl[3]  = '{8'h7F,  8'hFF,  1'b1, 16'hFF81, 8, 8, 8};
    tbl[4]  = '{8'd200, 8'd3,   1'b0, 16'h0258, 8, 3, 2};
    tbl[5]  = '{8'd7,   8'd0,   1'b0, 16'h0000, 8, 1, 0};
    tbl[6]  = '{8'd7,   8'd0,   1'b1, 16'h0000, 8, 8, 8};
    tbl[7]  = '{8'd1,   8'd128, 1'b0, 16'h0080, 8, 8, 8};
    tbl[8]  = '{8'd3,   8'd64,  1'b0, 16'h00C0, 8, 8, 7};
    tbl[9]  = '{8'd255, 8'd1,   1'b0, 16'h00FF, 8, 2, 1};
    tbl[10] = '{8'd0,   8'd255, 1'b0, 16'h0000, 8, 8, 8};
    tbl[11] = '{8'h80,  8'h7F,  1'b1, 16'hC080, 8, 8, 8};

    #2;
    chk("reset8", {40'd0, rdy8, ov8, busy8, ic8, p8, 2'd0}, {40'd0, 3'b100, 4'd0, 16'd0, 2'd0});
    chk("reset32", {rdy32, ov32, busy32, ic32, 55'd0}, {3'b100, 6'd0, 55'd0});
    chk("reset32_p", p32, 64'd0);
    #10 Reset_n = 1'b1;

    foreach (tbl[i])
      op8(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].ce, tbl[i].ie, 0,
          $sformatf("vec%0d", i));

    // stall in DONE for 5 cycles
    op8(8'd255, 8'd255, 1'b0, 16'hFE01, 8, 8, 8, 5, "stall");

    // async reset in the middle of iteration 4
    @(negedge clk); a8 = 8'd100; b8 = 8'd100; s8 = 1'b0; v8 = 1'b1;
    @(posedge clk); @(negedge clk); v8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("mid_iter", 64'(ic8), 64'd4);
    #1 Reset_n = 1'b0;
    #1 chk("rst_async", {41'd0, ov8, rdy8, busy8, ic8, p8}, {41'd0, 3'b010, 4'd0, 16'd0});
    #1 Reset_n = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (ov8 || ov8e) seen = 1; end
    chk("no_ov_after_rst", 64'(seen), 64'd0);
    op8(8'd12, 8'd11, 1'b0, 16'h0084, 8, 5, 4, 0, "after_rst");

    // randomized 8-bit ops: latency/iter_count predicted from the op's rules
    for (int n = 0; n < 150; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      if (n % 4 == 0) rb = rb >> $urandom_range(0, 8);
      m = msb8(rb);
      if (rs || m == 7)  begin rce = 8; rie = 8; end
      else if (m < 0)    begin rce = 1; rie = 0; end
      else               begin rce = m + 2; rie = m + 1; end
      op8(ra, rb, rs, ref8(ra, rb, rs), 8, rce, rie, n % 7 == 0 ? 2 : 0, "rnd8");
    end

    // randomized 32-bit ops with backpressure
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a32 = $urandom; b32 = $urandom; s32 = 1'($urandom);
      if (n % 5 == 0) a32 = 32'h8000_0000;
      e32 = ref32(a32, b32, s32);
      v32 = 1'b1;
      @(posedge clk);
      @(negedge clk); v32 = 1'b0; a32 = $urandom; b32 = $urandom;
      got = 0;
      for (int t = 0; t < 200 && got == 0; t++) begin
        if (t > 0) @(negedge clk);
        or32 = 1'($urandom);
        if (ov32 && or32) begin got = 1; chk("rnd32", p32, e32); end
        @(posedge clk);
      end
      if (got == 0) chk("rnd32_timeout", 64'd0, 64'd1);
      @(negedge clk); or32 = 1'b0;
      chk("rnd32_nodup", {62'd0, ov32, rdy32}, 64'b01);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
